bm_calc_wta: RTL and testbench
==============================

# bm_calc_wta

Winner-take-all disparity selector sitting directly downstream of the SAD engine in the stereo block-matching pipeline. Consumes the 34-lane SAD vector stream (`sad_in`/`vin`), finds the minimum-cost disparity among the PARALLEL candidate lanes per pixel, and merges it across disparity phases through a per-line buffer. Emits the final disparity/cost per pixel on the last phase. Generates the `sad_rdy` / `sad_line_end` handshake the SAD engine waits on.

## Interface
Reset: one clock; reset is synchronous and active-high.
- PARALLEL, 32, candidate lanes per phase; lanes PARALLEL and PARALLEL+1 of `sad_in` are overlap lanes and are ignored
- LBUF_DEPTH, 1024, line buffer entries
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enb  in  1  block enable; low forces IDLE
- ndisp  in  9  number of disparities (multiple of PARALLEL)
- hwsz  in  4  SAD half-window size
- hsad_wdt  in  10  HSAD line width
- dphase  in  4  current disparity phase, static during a line
- last_dphase  in  1  current phase is the final one
- out_rdy  in  1  downstream can accept a line (sampled in IDLE only)
- sad_in  in  544  34 × u16 SAD, lane k at [16k+15:16k]
- vin  in  1  `sad_in` valid
- sad_rdy  out  1  block can accept a new SAD line
- sad_line_end  out  1  one-cycle pulse, line fully consumed
- disp_out  out  9  winning disparity
- cost_out  out  16  winning SAD
- dout_vld  out  1  `disp_out`/`cost_out` valid, last phase only
- ovf_err  out  1  sticky: `vin` received outside RUN

## Operation
- owdt = hsad_wdt − 2·hwsz + 1, the number of `vin` beats per line.
- FSM states and transitions:
  - IDLE→RUN when `sad_rdy` and `vin`.
  - RUN→FLUSH on the beat where pix_cnt == owdt−1.
  - FLUSH lasts 3 cycles, then →DONE.
  - DONE lasts 1 cycle, pulses `sad_line_end`, then →IDLE.
  - `enb` low → IDLE from any state, with no `sad_line_end`.
- `sad_rdy` = (state==IDLE) & enb & (~last_dphase | out_rdy).
- pix_cnt: 10-bit counter, increments on `vin` in IDLE/RUN and clears in IDLE without `vin`. It is the line-buffer address.
- Lane mask: lane k has disparity d = dphase·PARALLEL + k. If d ≥ ndisp, the lane cost is forced to 16'hFFFF.
- Reduction: a 32→1 compare tree over (cost, d).
  - Strictly-less wins; a tie keeps the lower d.
  - Registered after level 2 and after level 5, giving 2 cycles.
- Merge stage (1 cycle):
  - dphase==0: prev = (16'hFFFF, 0).
  - Otherwise prev = line buffer[pix_cnt]. The read is issued at `vin`, and the data is aligned to the tree output.
  - The new candidate wins only if cost_new < cost_prev. A tie keeps prev, so the lower disparity is kept.
- Not last_dphase: write the merged (cost, d) to the buffer at the delayed pix_cnt.
- Last phase: drive `disp_out`/`cost_out`/`dout_vld`. The buffer is not written.
- `ovf_err` is set on `vin` in FLUSH/DONE, or in IDLE while `sad_rdy` is low. It is cleared only by `rst`.
- Saturated input (16'hFFFF on all lanes and prev) passes through unchanged: cost_out = FFFF, disp_out = 0.

## Timing
- Reset values: `sad_rdy`, `sad_line_end`, `dout_vld`, `ovf_err` = 0; `disp_out` = 0; `cost_out` = 0; FSM = IDLE; pix_cnt = 0.
- Latency is 3 cycles from `vin` to `dout_vld` or to the buffer write. Throughput is one pixel per cycle, back-to-back.
- `sad_line_end` asserts exactly 4 cycles after the last `vin` of the line. It therefore follows the last `dout_vld` or buffer write by 1 cycle.
- Read-after-write to the same address cannot occur within a line, since each address is touched once per phase.
- Reset mid-line:
  - The pipeline and outputs clear the next cycle.
  - Buffer contents are undefined until rewritten by a dphase 0 pass.
- `vin` gaps inside RUN are legal; the pipeline advances only with valid data (valid bits shift every cycle).

## Structure
- Shared package `bm_pkg`:
  - SAD_W=16 and DISP_W=9.
  - COST_MAX=16'hFFFF.
  - FSM state encoding.
  - Lane count 34.
- Sub-module `bm_wta_lbuf`: a simple dual-port RAM of LBUF_DEPTH × 25 bits (cost + disparity) with 1-cycle read latency. It maps to a single BRAM.
- The compare tree is a generate loop inside `bm_calc_wta`; it is not a separate module.

## Test plan
- Single phase (ndisp=32, dphase=0, last_dphase=1, hwsz=2, hsad_wdt=20):
  - Stimulus: 17 beats, each with lane 7 = 100 and all other lanes 500.
  - Required: 17 × `dout_vld` with disp_out = 7, cost_out = 100; `sad_line_end` 4 cycles after the last `vin`.
- Tie:
  - Stimulus: lanes 3 and 12 both = 50, all other lanes higher.
  - Required: disp_out = 3.
- Two phases (ndisp=64):
  - Stimulus: phase 0 best is lane 5 = 80. Phase 1 best is lane 2 = 60 at pixel 0 and lane 2 = 90 at pixel 1.
  - Required: pixel 0 gives disp = 34, cost = 60. Pixel 1 gives disp = 5, cost = 80.
- Mask:
  - Stimulus: ndisp=48, dphase=1, lane 20 = 1, lane 0 = 200.
  - Required: disp_out = 32, cost_out = 200.
- Handshake:
  - Stimulus: last_dphase=1, out_rdy=0.
  - Required: `sad_rdy` stays 0; a `vin` pulse sets `ovf_err`; raising out_rdy asserts `sad_rdy` the next cycle.
- Reset mid-line:
  - Stimulus: assert `rst` after 5 beats.
  - Required: all outputs 0 the next cycle and FSM in IDLE; a fresh dphase 0 line then produces correct results.

Source files
------------

// File: rtl/bm_pkg.sv
// ============================================================================
//  Module      : bm_pkg
//  Description : Shared types and constants for the block-matching WTA stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bm_pkg;

    localparam int SAD_W     = 16;
    localparam int DISP_W    = 9;
    localparam int NUM_LANES = 34;
    localparam int LBUF_W    = SAD_W + DISP_W;

    localparam logic [SAD_W-1:0] COST_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wta_state_t;

    typedef struct packed {
        logic [SAD_W-1:0]  cost;
        logic [DISP_W-1:0] disp;
    } wta_cand_t;

    // 'lo' must carry the lower disparity so ties resolve toward it.
    function automatic wta_cand_t wta_pick(input wta_cand_t lo, input wta_cand_t hi);
        return (hi.cost < lo.cost) ? hi : lo;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bm_wta_lbuf.sv
// ============================================================================
//  Module      : bm_wta_lbuf
//  Description : Simple dual-port line buffer holding the running best
//                (cost, disparity) per pixel; 1-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bm_wta_lbuf
    import bm_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  wta_cand_t     i_wdata,
    input  logic [AW-1:0] i_raddr,
    output wta_cand_t     o_rdata
);

    wta_cand_t r_mem [DEPTH];
    wta_cand_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/bm_calc_wta.sv
// ============================================================================
//  Module      : bm_calc_wta
//  Description : Winner-take-all disparity selector; reduces PARALLEL SAD lanes
//                per pixel and merges results across disparity phases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bm_calc_wta
    import bm_pkg::*;
#(
    parameter int PARALLEL   = 32,
    parameter int LBUF_DEPTH = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enb,
    input  logic [8:0]                       ndisp,
    input  logic [3:0]                       hwsz,
    input  logic [9:0]                       hsad_wdt,
    input  logic [3:0]                       dphase,
    input  logic                             last_dphase,
    input  logic                             out_rdy,
    input  logic [(PARALLEL+2)*SAD_W-1:0]    sad_in,
    input  logic                             vin,
    output logic                             sad_rdy,
    output logic                             sad_line_end,
    output logic [DISP_W-1:0]                disp_out,
    output logic [SAD_W-1:0]                 cost_out,
    output logic                             dout_vld,
    output logic                             ovf_err
);

    localparam int        c_cnt_w     = 10;
    localparam wta_cand_t c_cand_none = '{cost: COST_MAX, disp: '0};

    wta_state_t         r_state, w_state_nxt;
    logic [1:0]         r_flush_cnt;
    logic [c_cnt_w-1:0] r_pix_cnt;
    logic [c_cnt_w-1:0] w_owdt;
    logic               r_sad_rdy, r_ovf_err;
    logic               w_accept, w_last_beat;

    assign w_owdt      = hsad_wdt - {5'd0, hwsz, 1'b0} + 10'd1;
    assign w_accept    = vin & enb & (((r_state == ST_IDLE) & r_sad_rdy) | (r_state == ST_RUN));
    assign w_last_beat = w_accept & (r_pix_cnt == w_owdt - 10'd1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_last_beat ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (w_last_beat) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == 2'd2) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (!enb) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // sad_rdy is registered from the next state so it drops on the accepting beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= 2'd0;
            r_pix_cnt   <= '0;
            r_sad_rdy   <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 10'd1;
            end else if (r_state == ST_IDLE) begin
                r_pix_cnt <= '0;
            end
            r_sad_rdy <= (w_state_nxt == ST_IDLE) & enb & (~last_dphase | out_rdy);
            if (vin & ((r_state == ST_FLUSH) | (r_state == ST_DONE) |
                       ((r_state == ST_IDLE) & ~r_sad_rdy))) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign sad_rdy      = r_sad_rdy;
    assign ovf_err      = r_ovf_err;
    assign sad_line_end = (r_state == ST_DONE) & enb;

    logic [DISP_W-1:0] w_base;
    logic              w_unused_overlap;

    assign w_base           = DISP_W'(dphase) * DISP_W'(PARALLEL);
    assign w_unused_overlap = ^sad_in[(PARALLEL+2)*SAD_W-1:PARALLEL*SAD_W];

    wta_cand_t w_l0 [PARALLEL];
    wta_cand_t w_l1 [PARALLEL/2];
    wta_cand_t w_l2 [PARALLEL/4];
    wta_cand_t r_l2 [PARALLEL/4];
    wta_cand_t w_l3 [PARALLEL/8];
    wta_cand_t w_l4 [PARALLEL/16];
    wta_cand_t w_l5, r_l5;

    generate
        for (genvar k = 0; k < PARALLEL; k++) begin : g_lane
            logic [DISP_W-1:0] w_d;
            logic [SAD_W-1:0]  w_c;
            assign w_d     = w_base + DISP_W'(k);
            assign w_c     = (w_d >= ndisp) ? COST_MAX : sad_in[SAD_W*k +: SAD_W];
            assign w_l0[k] = {w_c, w_d};
        end
        for (genvar i = 0; i < PARALLEL/2; i++) begin : g_l1
            assign w_l1[i] = wta_pick(w_l0[2*i], w_l0[2*i+1]);
        end
        for (genvar i = 0; i < PARALLEL/4; i++) begin : g_l2
            assign w_l2[i] = wta_pick(w_l1[2*i], w_l1[2*i+1]);
        end
        for (genvar i = 0; i < PARALLEL/8; i++) begin : g_l3
            assign w_l3[i] = wta_pick(r_l2[2*i], r_l2[2*i+1]);
        end
        for (genvar i = 0; i < PARALLEL/16; i++) begin : g_l4
            assign w_l4[i] = wta_pick(w_l3[2*i], w_l3[2*i+1]);
        end
    endgenerate

    assign w_l5 = wta_pick(w_l4[0], w_l4[1]);

    logic               r_v1, r_v2;
    logic [c_cnt_w-1:0] r_addr1, r_addr2;
    wta_cand_t          r_prev, w_lbuf_rdata, w_merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
        end
        r_l2    <= w_l2;
        r_addr1 <= r_pix_cnt;
        r_l5    <= w_l5;
        r_addr2 <= r_addr1;
        r_prev  <= (dphase == 4'd0) ? c_cand_none : w_lbuf_rdata;
    end

    // Earlier phases always hold lower disparities, so prev takes the 'lo' side.
    assign w_merged = wta_pick(r_prev, r_l5);

    bm_wta_lbuf #(
        .DEPTH (LBUF_DEPTH),
        .AW    (c_cnt_w)
    ) u_lbuf (
        .clk     (clk),
        .i_we    (r_v2 & ~last_dphase),
        .i_waddr (r_addr2),
        .i_wdata (w_merged),
        .i_raddr (r_pix_cnt),
        .o_rdata (w_lbuf_rdata)
    );

    logic              r_dout_vld;
    logic [DISP_W-1:0] r_disp_out;
    logic [SAD_W-1:0]  r_cost_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_vld <= 1'b0;
            r_disp_out <= '0;
            r_cost_out <= '0;
        end else begin
            r_dout_vld <= r_v2 & last_dphase;
            if (r_v2 & last_dphase) begin
                r_disp_out <= w_merged.disp;
                r_cost_out <= w_merged.cost;
            end
        end
    end

    assign dout_vld = r_dout_vld;
    assign disp_out = r_disp_out;
    assign cost_out = r_cost_out;

endmodule

`default_nettype wire

// File: tb/tb_bm_calc_wta.sv
// ============================================================================
//  Module      : tb_bm_calc_wta
//  Description : Self-checking bench for bm_calc_wta with a per-pixel
//                scan model of the disparity search.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bm_calc_wta;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enb = 1'b1;
    logic [8:0]   ndisp = 9'd32;
    logic [3:0]   hwsz = 4'd2;
    logic [9:0]   hsad_wdt = 10'd20;
    logic [3:0]   dphase = 4'd0;
    logic         last_dphase = 1'b1;
    logic         out_rdy = 1'b1;
    logic [543:0] sad_in = '0;
    logic         vin = 1'b0;
    logic         sad_rdy, sad_line_end, dout_vld, ovf_err;
    logic [8:0]   disp_out;
    logic [15:0]  cost_out;

    bm_calc_wta dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .ndisp        (ndisp),
        .hwsz         (hwsz),
        .hsad_wdt     (hsad_wdt),
        .dphase       (dphase),
        .last_dphase  (last_dphase),
        .out_rdy      (out_rdy),
        .sad_in       (sad_in),
        .vin          (vin),
        .sad_rdy      (sad_rdy),
        .sad_line_end (sad_line_end),
        .disp_out     (disp_out),
        .cost_out     (cost_out),
        .dout_vld     (dout_vld),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int le_cnt = 0;
    int le_cyc = 0;

    typedef struct {
        int disp;
        int cost;
        int cyc;
    } obs_t;
    obs_t q[$];

    logic [543:0] line_sad [64];
    int           best_c [64];
    int           best_d [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_vld) begin
            obs_t o;
            o.disp = int'(disp_out);
            o.cost = int'(cost_out);
            o.cyc  = cyc;
            q.push_back(o);
        end
        if (sad_line_end) begin
            le_cnt++;
            le_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not terminate, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int owdt();
        return int'(hsad_wdt) - 2 * int'(hwsz) + 1;
    endfunction

    // Overlap lanes are set to 0 so that any leakage into the search would win.
    function automatic void fill_const(input int lane, input int lane_cost, input int other);
        for (int p = 0; p < 64; p++) begin
            for (int k = 0; k < 34; k++) begin
                line_sad[p][16*k +: 16] = (k >= 32) ? 16'd0 : 16'(other);
            end
            if (lane >= 0) line_sad[p][16*lane +: 16] = 16'(lane_cost);
        end
    endfunction

    function automatic void fill_random();
        for (int p = 0; p < 64; p++) begin
            for (int k = 0; k < 34; k++) begin
                line_sad[p][16*k +: 16] = ($urandom_range(0, 15) == 0) ? 16'hFFFF
                                                                       : 16'($urandom_range(0, 40));
            end
        end
    endfunction

    // Sequential scan in increasing disparity; strict less-than keeps the lowest d on ties.
    function automatic void model_phase();
        for (int p = 0; p < owdt(); p++) begin
            if (dphase == 4'd0) begin
                best_c[p] = 32'hFFFF;
                best_d[p] = 0;
            end
            for (int k = 0; k < 32; k++) begin
                int d;
                int c;
                d = int'(dphase) * 32 + k;
                c = (d >= int'(ndisp)) ? 32'hFFFF : int'(line_sad[p][16*k +: 16]);
                if (c < best_c[p]) begin
                    best_c[p] = c;
                    best_d[p] = d;
                end
            end
        end
    endfunction

    task automatic run_line(input string tag, input bit gaps);
        int t;
        int first_vin_cyc;
        int last_vin_cyc;
        int n;
        model_phase();
        q.delete();
        le_cnt = 0;
        t = 0;
        while (!sad_rdy && t < 50) begin
            tick();
            t++;
        end
        check({tag, "_sad_rdy"}, int'(sad_rdy), 1);
        first_vin_cyc = cyc;
        last_vin_cyc  = cyc;
        for (int p = 0; p < owdt(); p++) begin
            sad_in = line_sad[p];
            vin    = 1'b1;
            last_vin_cyc = cyc;
            tick();
            if (gaps && $urandom_range(0, 3) == 0) begin
                vin = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
        end
        vin = 1'b0;
        t = 0;
        while (le_cnt == 0 && t < 20) begin
            tick();
            t++;
        end
        tick();
        tick();
        check({tag, "_line_end_cnt"}, le_cnt, 1);
        check({tag, "_line_end_lat"}, le_cyc - last_vin_cyc, 4);
        if (last_dphase) begin
            check({tag, "_dout_cnt"}, q.size(), owdt());
            if (q.size() > 0) check({tag, "_dout_lat"}, q[0].cyc - first_vin_cyc, 3);
            n = (q.size() < owdt()) ? q.size() : owdt();
            for (int p = 0; p < n; p++) begin
                check($sformatf("%s_disp_p%0d", tag, p), q[p].disp, best_d[p]);
                check($sformatf("%s_cost_p%0d", tag, p), q[p].cost, best_c[p]);
            end
        end else begin
            check({tag, "_no_dout"}, q.size(), 0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_sad_rdy", int'(sad_rdy), 0);
        check("rst_line_end", int'(sad_line_end), 0);
        check("rst_dout_vld", int'(dout_vld), 0);
        check("rst_ovf_err", int'(ovf_err), 0);
        check("rst_disp_out", int'(disp_out), 0);
        check("rst_cost_out", int'(cost_out), 0);
        rst = 1'b0;
        tick();

        // Single phase, lane 7 best
        fill_const(7, 100, 500);
        run_line("single", 1'b0);

        // Tie between lanes 3 and 12
        fill_const(3, 50, 300);
        for (int p = 0; p < 64; p++) line_sad[p][16*12 +: 16] = 16'd50;
        run_line("tie", 1'b0);

        // Two phases, ndisp 64
        ndisp = 9'd64;
        dphase = 4'd0; last_dphase = 1'b0;
        fill_const(5, 80, 500);
        run_line("two_ph0", 1'b0);
        dphase = 4'd1; last_dphase = 1'b1;
        fill_const(2, 90, 500);
        line_sad[0][16*2 +: 16] = 16'd60;
        run_line("two_ph1", 1'b0);
        check("two_pix0_disp", q.size() > 0 ? q[0].disp : -1, 34);
        check("two_pix0_cost", q.size() > 0 ? q[0].cost : -1, 60);
        check("two_pix1_disp", q.size() > 1 ? q[1].disp : -1, 5);
        check("two_pix1_cost", q.size() > 1 ? q[1].cost : -1, 80);

        // Mask: lanes at d >= 48 forced to max cost
        ndisp = 9'd48;
        dphase = 4'd0; last_dphase = 1'b0;
        fill_const(-1, 0, 1000);
        run_line("mask_ph0", 1'b0);
        dphase = 4'd1; last_dphase = 1'b1;
        fill_const(20, 1, 700);
        for (int p = 0; p < 64; p++) line_sad[p][0 +: 16] = 16'd200;
        run_line("mask_ph1", 1'b0);
        check("mask_disp", q.size() > 0 ? q[0].disp : -1, 32);
        check("mask_cost", q.size() > 0 ? q[0].cost : -1, 200);

        // Saturated input
        ndisp = 9'd32; dphase = 4'd0; last_dphase = 1'b1;
        fill_const(-1, 0, 32'hFFFF);
        run_line("sat", 1'b0);

        // Random multi-phase lines with vin gaps
        for (int s = 0; s < 8; s++) begin
            int nph;
            nph = $urandom_range(1, 4);
            ndisp = 9'(nph * 32 - ((s % 3 == 0) ? $urandom_range(1, 31) : 0));
            hsad_wdt = 10'(20 + $urandom_range(0, 10));
            hwsz = 4'($urandom_range(1, 3));
            for (int ph = 0; ph < nph; ph++) begin
                dphase = 4'(ph);
                last_dphase = (ph == nph - 1);
                fill_random();
                run_line($sformatf("rnd%0d_ph%0d", s, ph), 1'b1);
            end
        end
        check("ovf_clean", int'(ovf_err), 0);

        // Handshake: downstream not ready on final phase
        hwsz = 4'd2; hsad_wdt = 10'd20; ndisp = 9'd32; dphase = 4'd0;
        last_dphase = 1'b1; out_rdy = 1'b0;
        q.delete();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("hs_sad_rdy_low", int'(sad_rdy), 0);
            tick();
        end
        vin = 1'b1;
        tick();
        vin = 1'b0;
        check("hs_ovf_set", int'(ovf_err), 1);
        check("hs_sad_rdy_still_low", int'(sad_rdy), 0);
        out_rdy = 1'b1;
        tick();
        check("hs_sad_rdy_rise", int'(sad_rdy), 1);
        repeat (4) tick();
        check("hs_no_dout", q.size(), 0);

        // Reset mid-line
        fill_random();
        for (int p = 0; p < 5; p++) begin
            sad_in = line_sad[p];
            vin = 1'b1;
            tick();
        end
        vin = 1'b0;
        rst = 1'b1;
        tick();
        check("mrst_sad_rdy", int'(sad_rdy), 0);
        check("mrst_line_end", int'(sad_line_end), 0);
        check("mrst_dout_vld", int'(dout_vld), 0);
        check("mrst_ovf_err", int'(ovf_err), 0);
        check("mrst_disp_out", int'(disp_out), 0);
        check("mrst_cost_out", int'(cost_out), 0);
        rst = 1'b0;
        fill_random();
        run_line("after_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
